// File: rtl/writeback_stage_p_if.sv
// MEM/WB bus of the writeback stage: instruction fields in, writeback results out.
// The slave side is the stage itself; the master side is whatever feeds and observes it.
interface writeback_stage_p_if #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  logic             stall;
  logic             flush;
  logic             in_valid;
  logic [XLEN-1:0]  result_alu;
  logic [XLEN-1:0]  data_mem;
  logic             mem_ready;
  logic             MemToReg;
  logic [2:0]       in_MemFunct;
  logic             in_RegWrite;
  logic [REG_W-1:0] in_RegDest;
  logic             in_PCSrc;
  logic [XLEN-1:0]  in_BranchTarget;

  logic [XLEN-1:0]  data_wb;
  logic             out_RegWrite;
  logic [REG_W-1:0] out_RegDest;
  logic             out_PCSrc;
  logic [XLEN-1:0]  out_BranchTarget;
  logic             out_valid;
  logic             wb_busy;
  logic             mem_error;
  logic [CNT_W-1:0] retired_count;

  modport master (
    output stall, flush, in_valid, result_alu, data_mem, mem_ready, MemToReg,
           in_MemFunct, in_RegWrite, in_RegDest, in_PCSrc, in_BranchTarget,
    input  data_wb, out_RegWrite, out_RegDest, out_PCSrc, out_BranchTarget,
           out_valid, wb_busy, mem_error, retired_count
  );

  modport slave (
    input  stall, flush, in_valid, result_alu, data_mem, mem_ready, MemToReg,
           in_MemFunct, in_RegWrite, in_RegDest, in_PCSrc, in_BranchTarget,
    output data_wb, out_RegWrite, out_RegDest, out_PCSrc, out_BranchTarget,
           out_valid, wb_busy, mem_error, retired_count
  );
endinterface

// File: rtl/writeback_stage_p.sv
// Writeback stage: MEM/WB register, RV-style load lane extraction, memory-wait
// handshake with timeout, and a retired-instruction counter.
module writeback_stage_p #(
  parameter int XLEN        = 32,
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  writeback_stage_p_if.slave   bus
);

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(MEM_TIMEOUT - 1);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic             valid_q,  valid_d;
  logic             mtr_q,    mtr_d;
  logic [2:0]       funct_q,  funct_d;
  logic             rw_q,     rw_d;
  logic [REG_W-1:0] dest_q,   dest_d;
  logic             pcsrc_q,  pcsrc_d;
  logic [XLEN-1:0]  tgt_q,    tgt_d;
  logic [XLEN-1:0]  alu_q,    alu_d;
  logic             done_q,   done_d;
  logic [0:0]       state_q,  state_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             merr_q,   merr_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic             busy;
  logic             timeout;
  logic             retire;
  logic [2:0]       off;

  // Byte/half/word lane pick; misaligned offsets simply drop the low index bits.
  function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] w,
                                               input logic [2:0]      f,
                                               input logic [2:0]      o);
    logic [XLEN-1:0]    sb, sh, sw;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] wd;
    logic [XLEN-1:0]    r;
    sb = w >> {o, 3'b000};
    sh = w >> {o[2:1], 4'b0000};
    sw = w >> {o[2], 5'b00000};
    b  = sb[7:0];
    h  = sh[15:0];
    wd = sw[31:0];
    case (f)
      3'b000:  r = XLEN'(b);
      3'b100:  r = XLEN'($unsigned(b));
      3'b001:  r = XLEN'(h);
      3'b101:  r = XLEN'($unsigned(h));
      3'b010:  r = XLEN'(wd);
      3'b110:  r = (XLEN == 64) ? XLEN'($unsigned(wd)) : w;
      default: r = w;
    endcase
    return r;
  endfunction

  always_comb begin
    busy    = valid_q & mtr_q & ~bus.mem_ready;
    timeout = (MEM_TIMEOUT != 0) && busy && (cnt_q == TO_LAST);
    retire  = valid_q & ~busy & ~done_q & ~bus.flush;
    off     = (XLEN == 64) ? alu_q[2:0] : {1'b0, alu_q[1:0]};

    valid_d   = valid_q;
    mtr_d     = mtr_q;
    funct_d   = funct_q;
    rw_d      = rw_q;
    dest_d    = dest_q;
    pcsrc_d   = pcsrc_q;
    tgt_d     = tgt_q;
    alu_d     = alu_q;
    done_d    = done_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    merr_d    = timeout & ~bus.flush;
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

    case (state_q)
      ST_IDLE: begin
        if (busy) begin
          state_d = ST_WAIT;
          cnt_d   = cnt_q + CW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      default: begin
        if (!busy) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
    endcase
    if (timeout || bus.flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end

    // A stalled entry keeps its done bit so it is only ever counted once.
    if (bus.flush || timeout) begin
      valid_d = 1'b0;
    end else if (bus.stall || busy) begin
      done_d  = done_q | retire;
    end else begin
      valid_d = bus.in_valid;
      mtr_d   = bus.MemToReg;
      funct_d = bus.in_MemFunct;
      rw_d    = bus.in_RegWrite;
      dest_d  = bus.in_RegDest;
      pcsrc_d = bus.in_PCSrc;
      tgt_d   = bus.in_BranchTarget;
      alu_d   = bus.result_alu;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      mtr_q     <= 1'b0;
      funct_q   <= '0;
      rw_q      <= 1'b0;
      dest_q    <= '0;
      pcsrc_q   <= 1'b0;
      tgt_q     <= '0;
      alu_q     <= '0;
      done_q    <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      merr_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      valid_q   <= valid_d;
      mtr_q     <= mtr_d;
      funct_q   <= funct_d;
      rw_q      <= rw_d;
      dest_q    <= dest_d;
      pcsrc_q   <= pcsrc_d;
      tgt_q     <= tgt_d;
      alu_q     <= alu_d;
      done_q    <= done_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      merr_q    <= merr_d;
      retired_q <= retired_d;
    end
  end

  assign bus.data_wb          = mtr_q ? fmt_load(bus.data_mem, funct_q, off) : alu_q;
  assign bus.out_RegWrite     = valid_q & rw_q & ~busy;
  assign bus.out_RegDest      = dest_q;
  assign bus.out_PCSrc        = valid_q & pcsrc_q;
  assign bus.out_BranchTarget = tgt_q;
  assign bus.out_valid        = valid_q;
  assign bus.wb_busy          = busy;
  assign bus.mem_error        = merr_q;
  assign bus.retired_count    = retired_q;

endmodule
